// File: rtl/clint_pkg.sv
// CLINT shared types: register offsets, bus FSM states, reset constants.
// Build option: CLINT_MSIP_EN enables the msip register.
package clint_pkg;

  localparam logic [15:0] MSIP_OFF     = 16'h0000;
  localparam logic [15:0] MTIMECMP_OFF = 16'h4000;
  localparam logic [15:0] MTIME_OFF    = 16'hBFF8;

  localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic {
    IDLE,
    RESP
  } state_t;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_MSIP,
    SEL_CMP,
    SEL_TIME
  } sel_t;

  function automatic sel_t decode(input logic [15:0] a);
    sel_t s;
    s = SEL_NONE;
    if (a[15:3] == MSIP_OFF[15:3])
      s = SEL_MSIP;
    else if (a[15:3] == MTIMECMP_OFF[15:3])
      s = SEL_CMP;
    else if (a[15:3] == MTIME_OFF[15:3])
      s = SEL_TIME;
    return s;
  endfunction

  function automatic logic [63:0] wmerge(
    input logic [63:0] old,
    input logic [63:0] wd,
    input logic [7:0]  st
  );
    logic [63:0] r;
    for (int i = 0; i < 8; i++)
      r[i*8 +: 8] = st[i] ? wd[i*8 +: 8]
                          : old[i*8 +: 8];
    return r;
  endfunction

endpackage

// File: rtl/clint_if.sv
// CLINT request/response bus: valid/ready request, valid/ready response.
// Build option: CLINT_MSIP_EN (no effect on this interface).
interface clint_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [15:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr,
    output req_wdata, req_wstrb, rsp_ready,
    input  req_ready, rsp_valid,
    input  rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr,
    input  req_wdata, req_wstrb, rsp_ready,
    output req_ready, rsp_valid,
    output rsp_rdata, rsp_err
  );

endinterface

// File: rtl/clint_timer.sv
// CLINT timer: prescaler, 64-bit mtime, mtimecmp and registered mtip.
// Build option: CLINT_MSIP_EN (no effect on this module).
module clint_timer
  import clint_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        time_we,
  input  logic        cmp_we,
  input  logic [63:0] wdata,
  input  logic [7:0]  wstrb,
  output logic [63:0] mtime,
  output logic [63:0] mtimecmp,
  output logic        mtip
);

  logic [15:0] presc;
  logic        tick;

  assign tick = (presc == 16'(TICK_DIV - 1));

  // bus write to mtime beats the tick; prescaler keeps running
  always_ff @(posedge clk) begin
    if (rst) begin
      presc    <= '0;
      mtime    <= '0;
      mtimecmp <= MTIMECMP_RST;
      mtip     <= 1'b0;
    end else begin
      presc <= tick ? '0 : presc + 16'd1;
      if (time_we)
        mtime <= wmerge(mtime, wdata, wstrb);
      else if (tick)
        mtime <= mtime + 64'd1;
      if (cmp_we)
        mtimecmp <= wmerge(mtimecmp, wdata, wstrb);
      mtip <= (mtime >= mtimecmp);
    end
  end

endmodule

// File: rtl/clint_slave.sv
// CLINT bus slave: two-state request/response FSM over clint_timer.
// Build option: CLINT_MSIP_EN enables the msip register at 0x0000.
module clint_slave
  import clint_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic   clk,
  input  logic   rst,
  clint_if.slave bus,
  output logic   mtip,
  output logic   msip
);

  state_t      state;
  sel_t        sel;
  logic        acc;
  logic        wr;
  logic        msip_q;
  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic [63:0] rd_val;

  assign sel           = decode(bus.req_addr);
  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = (state == RESP);
  assign acc           = bus.req_valid && bus.req_ready;
  assign wr            = acc && bus.req_we;
  assign msip          = msip_q;

  clint_timer #(
    .TICK_DIV (TICK_DIV)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .time_we  (wr && (sel == SEL_TIME)),
    .cmp_we   (wr && (sel == SEL_CMP)),
    .wdata    (bus.req_wdata),
    .wstrb    (bus.req_wstrb),
    .mtime    (mtime),
    .mtimecmp (mtimecmp),
    .mtip     (mtip)
  );

`ifdef CLINT_MSIP_EN
  always_ff @(posedge clk) begin
    if (rst)
      msip_q <= 1'b0;
    else if (wr && (sel == SEL_MSIP) && bus.req_wstrb[0])
      msip_q <= bus.req_wdata[0];
  end
`else
  assign msip_q = 1'b0;
`endif

  always_comb begin
    rd_val = '0;
    unique case (1'b1)
      (sel == SEL_MSIP): rd_val = {63'd0, msip_q};
      (sel == SEL_CMP):  rd_val = mtimecmp;
      (sel == SEL_TIME): rd_val = mtime;
      default:           rd_val = '0;
    endcase
  end

  // response fields only change on accept, so they hold while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (acc) begin
            state         <= RESP;
            bus.rsp_err   <= (sel == SEL_NONE);
            bus.rsp_rdata <= bus.req_we ? '0 : rd_val;
          end
        end
        RESP: begin
          if (bus.rsp_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/clint_slave.md
CLINT_SLAVE -- requirements
Module: clint_slave

Interface
REQ-001 Parameter TICK_DIV, default 1, SHALL set the clk cycles per mtime increment (legal 1..65535).
REQ-002 Port clk  input  1  SHALL be the clock; all state updates on its rising edge.
REQ-003 Port rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-004 Port req_valid  input  1  SHALL mark a valid bus request.
REQ-005 Port req_ready  output  1  SHALL mark that a request can be accepted.
REQ-006 Port req_we  input  1  SHALL select write (1) or read (0).
REQ-007 Port req_addr  input  16  SHALL carry the byte offset within the CLINT window.
REQ-008 Port req_wdata  input  64  SHALL carry write data.
REQ-009 Port req_wstrb  input  8  SHALL carry byte enables for writes.
REQ-010 Port rsp_valid  output  1  SHALL mark a valid response.
REQ-011 Port rsp_ready  input  1  SHALL mark that the requester accepts the response.
REQ-012 Port rsp_rdata  output  64  SHALL carry read data (0 on writes and errors).
REQ-013 Port rsp_err  output  1  SHALL flag an unmapped address.
REQ-014 Port mtip  output  1  SHALL be the machine timer interrupt pending level toward the CSR file.
REQ-015 Port msip  output  1  SHALL be the machine software interrupt pending level toward the CSR file.

Function
REQ-016 Register map SHALL be: msip 0x0000 (bit 0 only, others read 0), mtimecmp 0x4000 (64-bit), mtime 0xBFF8 (64-bit); addr[2:0] ignored within each register.
REQ-017 FSM SHALL have states IDLE and RESP; req_ready = (state==IDLE).
REQ-018 IDLE->RESP on req_valid&&req_ready; RESP->IDLE on rsp_valid&&rsp_ready; rsp_valid = (state==RESP).
REQ-019 Response SHALL appear exactly one cycle after acceptance and hold rsp_rdata/rsp_err stable until accepted; back-to-back throughput is one request per two cycles.
REQ-020 Writes SHALL take effect on the accept edge, merging only bytes with req_wstrb set.
REQ-021 Reads SHALL capture the register value at the accept edge.
REQ-022 Unmapped offsets SHALL produce rsp_err=1, rsp_rdata=0, no state change.
REQ-023 A prescaler SHALL count 0..TICK_DIV-1; mtime SHALL increment by 1 when it wraps; mtime wraps 64'hFFFF_FFFF_FFFF_FFFF -> 0.
REQ-024 A bus write to mtime SHALL win over a same-cycle increment; the prescaler SHALL not reset on that write.
REQ-025 mtip SHALL be registered: mtip = (mtime >= mtimecmp, unsigned) evaluated one cycle earlier.
REQ-026 Writing mtimecmp > mtime SHALL deassert mtip the following cycle (level, no latching).
REQ-027 msip output SHALL equal msip register bit 0.

Reset
REQ-028 On rst: state=IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, prescaler=0, mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, msip=0, mtip=0.
REQ-029 rst in RESP SHALL drop the pending response without completion.

Configuration
REQ-030 With CLINT_MSIP_EN defined, the msip register SHALL be implemented per REQ-016/027.
REQ-031 Without CLINT_MSIP_EN, offset 0x0000 SHALL read 0 with rsp_err=0, writes are ignored, msip tied 0.

Structure
REQ-032 Package clint_pkg SHALL hold register offsets, the FSM state typedef and the mtimecmp reset constant.
REQ-033 Sub-module clint_timer SHALL hold prescaler, mtime and the mtip compare; bus FSM stays in clint_slave.

Verification
REQ-034 Reset, TICK_DIV=1, idle 10 cycles -> read 0xBFF8 returns 10 or 11 (±1 for the read cycle), mtip=0.
REQ-035 Write mtimecmp=0x20, TICK_DIV=1 -> mtip rises the cycle after mtime reaches 0x20; write mtimecmp=0xFFFF -> mtip=0 next cycle.
REQ-036 Write mtime=0xFFFF_FFFF_FFFF_FFFE -> read after 3 cycles returns wrapped value 0 or 1.
REQ-037 Write mtimecmp wstrb=0x0F data 0x1234_5678 from all-ones -> reads 0xFFFF_FFFF_1234_5678.
REQ-038 Read 0x1000 -> rsp_err=1, rsp_rdata=0; hold rsp_ready=0 for 5 cycles -> rsp_valid and data stable, req_ready=0.
REQ-039 With CLINT_MSIP_EN, write 0x0000=1 -> msip=1, read returns 1; without it -> msip=0, read returns 0.
